// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and helpers for the 7-segment bus snooper.
//  - SEG_0..SEG_F: glyphs produced by the hex->7-seg driver (bit6=a .. bit0=g).
//    The driver's B and D glyphs alias 2 and 0.
//  - SEG_LB / SEG_LD: lowercase b / d glyphs, legal only with SEG_LOWER_BD_EN.
//  - ST_IDLE / ST_SETTLE / ST_HOLD: capture FSM encoding.
//  - is_onehot8 / onehot_idx8: strobe helpers on a zero-extended 8-bit strobe.
package seg_pkg;

  localparam logic [6:0] SEG_0  = 7'h7E;
  localparam logic [6:0] SEG_1  = 7'h30;
  localparam logic [6:0] SEG_2  = 7'h6D;
  localparam logic [6:0] SEG_3  = 7'h79;
  localparam logic [6:0] SEG_4  = 7'h33;
  localparam logic [6:0] SEG_5  = 7'h5B;
  localparam logic [6:0] SEG_6  = 7'h5F;
  localparam logic [6:0] SEG_7  = 7'h70;
  localparam logic [6:0] SEG_8  = 7'h7F;
  localparam logic [6:0] SEG_9  = 7'h7B;
  localparam logic [6:0] SEG_A  = 7'h77;
  localparam logic [6:0] SEG_B  = SEG_2;
  localparam logic [6:0] SEG_C  = 7'h4E;
  localparam logic [6:0] SEG_D  = SEG_0;
  localparam logic [6:0] SEG_E  = 7'h4F;
  localparam logic [6:0] SEG_F  = 7'h47;
  localparam logic [6:0] SEG_LB = 7'h1F;
  localparam logic [6:0] SEG_LD = 7'h3D;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Exactly one bit set.
  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  // Index of the set bit; only meaningful when v is one-hot.
  function automatic logic [2:0] onehot_idx8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_to_hex.sv
// seg_to_hex: combinational 7-segment pattern decoder.
//  seg   in  7  segment pattern, bit6=a .. bit0=g, 1=lit
//  legal out 1  pattern is one of the recognised glyphs
//  nib   out 4  decoded value (0 when illegal)
// Configuration macro SEG_LOWER_BD_EN: also accept lowercase b (7'h1F) and d (7'h3D).
module seg_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nib
);

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    // B and D alias 2 and 0, so they need no case items of their own.
    case (seg)
      SEG_0:   nib = 4'h0;
      SEG_1:   nib = 4'h1;
      SEG_2:   nib = 4'h2;
      SEG_3:   nib = 4'h3;
      SEG_4:   nib = 4'h4;
      SEG_5:   nib = 4'h5;
      SEG_6:   nib = 4'h6;
      SEG_7:   nib = 4'h7;
      SEG_8:   nib = 4'h8;
      SEG_9:   nib = 4'h9;
      SEG_A:   nib = 4'hA;
      SEG_C:   nib = 4'hC;
      SEG_E:   nib = 4'hE;
      SEG_F:   nib = 4'hF;
`ifdef SEG_LOWER_BD_EN
      SEG_LB:  nib = 4'hB;
      SEG_LD:  nib = 4'hD;
`else
      // Lowercase b/d fall through to the illegal default.
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: snoops a multiplexed 7-segment display bus and recovers the
// nibble shown on each digit once the pattern has been stable.
//  clk       in   1       clock, rising edge
//  rst_n     in   1       synchronous reset, active low
//  seg_i     in   7       segment lines, bit6=a .. bit0=g
//  dig_i     in   NDIG    one-hot digit strobes, all-zero = blanking
//  clr_i     in   1       clears vld_o, err_o, seen mask, cap_o, frame_o
//  val_o     out  4*NDIG  recovered nibbles, digit k at [4k+3:4k]
//  vld_o     out  NDIG    sticky per-digit captured flags
//  cap_o     out  1       one-cycle capture pulse
//  cap_idx_o out  3       digit index of the last capture
//  err_o     out  1       sticky illegal-pattern / multi-hot flag
//  frame_o   out  1       one-cycle pulse once every digit has been captured
// Configuration macro SEG_LOWER_BD_EN (handled inside seg_to_hex).
module seg_capture
  import seg_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_i,
  input  logic [NDIG-1:0]   dig_i,
  input  logic              clr_i,
  output logic [4*NDIG-1:0] val_o,
  output logic [NDIG-1:0]   vld_o,
  output logic              cap_o,
  output logic [2:0]        cap_idx_o,
  output logic              err_o,
  output logic              frame_o
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Sample stage and the previous sample for the stability compare.
  logic [NDIG-1:0]   dig_q, dig_p;
  logic [6:0]        seg_q, seg_p;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4*NDIG-1:0] val_q, val_d;
  logic [NDIG-1:0]   vld_q, vld_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic              cap_q, cap_d;
  logic [2:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic              frame_q, frame_d;

  logic [7:0]        dig8;
  logic              same, oh, zero, multi, decode;
  logic              legal;
  logic [3:0]        nib;

  seg_to_hex u_dec (
    .seg   (seg_q),
    .legal (legal),
    .nib   (nib)
  );

  always_comb begin
    dig8             = 8'h00;
    dig8[NDIG-1:0]   = dig_q;
  end

  assign same  = (dig_q == dig_p) && (seg_q == seg_p);
  assign oh    = is_onehot8(dig8);
  assign zero  = (dig_q == '0);
  assign multi = !oh && !zero;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    vld_d   = vld_q;
    seen_d  = seen_q;
    cap_d   = 1'b0;
    idx_d   = idx_q;
    err_d   = err_q;
    frame_d = 1'b0;
    decode  = 1'b0;

    // Full frame seen by the previous capture: pulse and restart the mask.
    if (seen_q == {NDIG{1'b1}}) begin
      frame_d = 1'b1;
      seen_d  = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (oh) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (!same) begin
          cnt_d = CNT_ONE;
          if (!oh) state_d = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          decode  = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (!oh) begin
          state_d = ST_IDLE;
        end else if (!same) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (multi) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    // A clear in the decode cycle discards the event; the FSM still moves on.
    if (decode && !clr_i) begin
      if (legal) begin
        for (int k = 0; k < NDIG; k++) begin
          if (dig_q[k]) begin
            val_d[4*k +: 4] = nib;
            vld_d[k]        = 1'b1;
            seen_d[k]       = 1'b1;
          end
        end
        cap_d = 1'b1;
        idx_d = onehot_idx8(dig8);
      end else begin
        err_d = 1'b1;
      end
    end

    if (clr_i) begin
      vld_d   = '0;
      err_d   = 1'b0;
      seen_d  = '0;
      cap_d   = 1'b0;
      frame_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_q   <= '0;
      seg_q   <= '0;
      dig_p   <= '0;
      seg_p   <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      vld_q   <= '0;
      seen_q  <= '0;
      cap_q   <= 1'b0;
      idx_q   <= 3'd0;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      dig_q   <= dig_i;
      seg_q   <= seg_i;
      dig_p   <= dig_q;
      seg_p   <= seg_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
      seen_q  <= seen_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end

  assign val_o     = val_q;
  assign vld_o     = vld_q;
  assign cap_o     = cap_q;
  assign cap_idx_o = idx_q;
  assign err_o     = err_q;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed, table-driven bench for seg_capture (NDIG=4, STABLE_CYC=3).
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_seg_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_i;
  logic [6:0]  seg_i;
  logic [3:0]  dig_i;
  logic [15:0] val_o;
  logic [3:0]  vld_o;
  logic        cap_o;
  logic [2:0]  cap_idx_o;
  logic        err_o;
  logic        frame_o;

  int checks = 0;
  int errors = 0;

  // Event monitor; only this process writes these.
  int cap_cnt = 0;
  int frame_cnt = 0;
  int cyc = 0;
  int last_cap_cyc = 0;
  int frame_cyc = 0;

  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       legal;
    logic [3:0] nib;
    int         idx;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  seg_capture #(
    .NDIG       (4),
    .STABLE_CYC (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_i     (seg_i),
    .dig_i     (dig_i),
    .clr_i     (clr_i),
    .val_o     (val_o),
    .vld_o     (vld_o),
    .cap_o     (cap_o),
    .cap_idx_o (cap_idx_o),
    .err_o     (err_o),
    .frame_o   (frame_o)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (cap_o) begin
        cap_cnt      = cap_cnt + 1;
        last_cap_cyc = cyc;
      end
      if (frame_o) begin
        frame_cnt = frame_cnt + 1;
        frame_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks = checks + 1;
    if (act !== exp_v) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
    dig_i = d;
    seg_i = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    dig_i = 4'b0000;
    seg_i = 7'h00;
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] exp_val;
    int          base_cap;
    int          base_frame;
    vec_t        v;

    vecs[0]  = '{4'b0001, 7'h7E, 1'b1, 4'h0, 0};
    vecs[1]  = '{4'b0010, 7'h30, 1'b1, 4'h1, 1};
    vecs[2]  = '{4'b0100, 7'h6D, 1'b1, 4'h2, 2};
    vecs[3]  = '{4'b1000, 7'h79, 1'b1, 4'h3, 3};
    vecs[4]  = '{4'b0001, 7'h33, 1'b1, 4'h4, 0};
    vecs[5]  = '{4'b0010, 7'h5B, 1'b1, 4'h5, 1};
    vecs[6]  = '{4'b0100, 7'h5F, 1'b1, 4'h6, 2};
    vecs[7]  = '{4'b1000, 7'h70, 1'b1, 4'h7, 3};
    vecs[8]  = '{4'b0001, 7'h7F, 1'b1, 4'h8, 0};
    vecs[9]  = '{4'b0010, 7'h7B, 1'b1, 4'h9, 1};
    vecs[10] = '{4'b0100, 7'h77, 1'b1, 4'hA, 2};
    vecs[11] = '{4'b1000, 7'h4E, 1'b1, 4'hC, 3};
    vecs[12] = '{4'b0001, 7'h4F, 1'b1, 4'hE, 0};
    vecs[13] = '{4'b0010, 7'h47, 1'b1, 4'hF, 1};
    vecs[14] = '{4'b0100, 7'h00, 1'b0, 4'h0, 2};
`ifdef SEG_LOWER_BD_EN
    vecs[15] = '{4'b1000, 7'h1F, 1'b1, 4'hB, 3};
    vecs[16] = '{4'b0001, 7'h3D, 1'b1, 4'hD, 0};
`else
    vecs[15] = '{4'b1000, 7'h1F, 1'b0, 4'h0, 3};
    vecs[16] = '{4'b0001, 7'h3D, 1'b0, 4'h0, 0};
`endif
    vecs[17] = '{4'b0010, 7'h7D, 1'b0, 4'h0, 1};

    // Reset with active inputs.
    rst_n = 1'b0;
    clr_i = 1'b0;
    dig_i = 4'b0001;
    seg_i = 7'h5B;
    repeat (6) @(negedge clk);
    chk("reset val", 32'(val_o), 32'h0);
    chk("reset vld", 32'(vld_o), 32'h0);
    chk("reset cap", 32'(cap_o), 32'h0);
    chk("reset idx", 32'(cap_idx_o), 32'h0);
    chk("reset err", 32'(err_o), 32'h0);
    chk("reset frame", 32'(frame_o), 32'h0);

    dig_i = 4'b0000;
    seg_i = 7'h00;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post-reset no cap", 32'(cap_cnt), 32'd0);

    // Single stable digit.
    exp_val  = 16'h0000;
    base_cap = cap_cnt;
    drive(4'b0001, 7'h5B, 5);
    drive(4'b0000, 7'h00, 3);
    exp_val[3:0] = 4'h5;
    chk("single cap count", 32'(cap_cnt - base_cap), 32'd1);
    chk("single idx", 32'(cap_idx_o), 32'd0);
    chk("single val", 32'(val_o), 32'(exp_val));
    chk("single vld", 32'(vld_o), 32'b0001);

    // Stability boundary: 3 stable sample cycles is one short, 4 is enough.
    pulse_clr();
    base_cap = cap_cnt;
    drive(4'b0010, 7'h30, 3);
    drive(4'b0000, 7'h00, 4);
    chk("short hold no cap", 32'(cap_cnt - base_cap), 32'd0);
    drive(4'b0010, 7'h30, 4);
    drive(4'b0000, 7'h00, 3);
    exp_val[7:4] = 4'h1;
    chk("exact hold cap", 32'(cap_cnt - base_cap), 32'd1);
    chk("exact hold idx", 32'(cap_idx_o), 32'd1);
    chk("exact hold val", 32'(val_o), 32'(exp_val));

    // Toggling faster than the stability window never captures.
    base_cap = cap_cnt;
    for (int i = 0; i < 6; i++) begin
      drive(4'b0100, 7'h30, 2);
      drive(4'b0100, 7'h6D, 2);
    end
    drive(4'b0000, 7'h00, 3);
    chk("toggle no cap", 32'(cap_cnt - base_cap), 32'd0);
    chk("toggle val", 32'(val_o), 32'(exp_val));

    // Decode table.
    for (int i = 0; i < 18; i++) begin
      v = vecs[i];
      pulse_clr();
      base_cap = cap_cnt;
      drive(v.dig, v.seg, 5);
      drive(4'b0000, 7'h00, 3);
      if (v.legal) exp_val[v.idx*4 +: 4] = v.nib;
      chk($sformatf("vec%0d cap", i), 32'(cap_cnt - base_cap), v.legal ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d err", i), 32'(err_o), v.legal ? 32'd0 : 32'd1);
      chk($sformatf("vec%0d vld", i), 32'(vld_o), v.legal ? 32'(v.dig) : 32'd0);
      chk($sformatf("vec%0d val", i), 32'(val_o), 32'(exp_val));
      if (v.legal) chk($sformatf("vec%0d idx", i), 32'(cap_idx_o), 32'(v.idx));
    end

    // Full scan of four digits produces one frame pulse right after the last capture.
    pulse_clr();
    base_cap   = cap_cnt;
    base_frame = frame_cnt;
    drive(4'b0001, 7'h30, 4);
    drive(4'b0010, 7'h6D, 4);
    drive(4'b0100, 7'h79, 4);
    drive(4'b1000, 7'h33, 4);
    drive(4'b0000, 7'h00, 6);
    exp_val = 16'h4321;
    chk("scan cap count", 32'(cap_cnt - base_cap), 32'd4);
    chk("scan frame count", 32'(frame_cnt - base_frame), 32'd1);
    chk("scan frame timing", 32'(frame_cyc - last_cap_cyc), 32'd1);
    chk("scan val", 32'(val_o), 32'(exp_val));
    chk("scan vld", 32'(vld_o), 32'b1111);
    chk("scan last idx", 32'(cap_idx_o), 32'd3);

    // Illegal pattern, then multi-hot strobe, then clear.
    pulse_clr();
    base_cap = cap_cnt;
    drive(4'b0010, 7'h00, 5);
    chk("illegal err", 32'(err_o), 32'd1);
    chk("illegal vld", 32'(vld_o), 32'd0);
    drive(4'b0011, 7'h30, 5);
    chk("multihot err", 32'(err_o), 32'd1);
    chk("multihot no cap", 32'(cap_cnt - base_cap), 32'd0);
    drive(4'b0000, 7'h00, 2);
    pulse_clr();
    chk("clr err", 32'(err_o), 32'd0);
    chk("clr keeps val", 32'(val_o), 32'(exp_val));

    // Clear coinciding with the decode cycle discards the event; no re-capture in HOLD.
    base_cap = cap_cnt;
    drive(4'b1000, 7'h1F, 4);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    drive(4'b1000, 7'h1F, 4);
    drive(4'b0000, 7'h00, 3);
    chk("clr-on-cap no cap", 32'(cap_cnt - base_cap), 32'd0);
    chk("clr-on-cap err", 32'(err_o), 32'd0);
    chk("clr-on-cap vld", 32'(vld_o), 32'd0);
    chk("clr-on-cap val", 32'(val_o), 32'(exp_val));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
